rab_ram_tp_ctrl: RTL
====================

# rab_ram_tp_ctrl

Controller that owns one two-port no-change block RAM (port 0 read/write, port 1 read-only) and shares it between a configuration requester and a lookup requester in the RAB. After reset or on request it sweeps the whole RAM to a clear value, because BRAM contents have no reset. It serialises configuration reads and writes on port 0 and streams lookups on port 1 through a 2-entry response buffer. It also hides the port-1 read-after-write hazard, where port 1 returns invalid data in the cycle after a write to the same address.

## Interface
- `ADDR_WIDTH`, default 10: RAM address width. DEPTH = 2**ADDR_WIDTH.
- `DATA_WIDTH`, default 36: RAM word width.
- `CLEAR_VALUE`, default 0: value written to every entry during a sweep.

Clock and reset: one clock, `clk`; reset `rst_n` is synchronous and active-low.

- `clk`  in  1  clock
- `rst_n`  in  1  synchronous active-low reset
- `clear_req_i`  in  1  single-cycle pulse; requests a new sweep
- `init_done_o`  out  1  high while in RUN
- `cfg_req_valid_i`  in  1  config request valid
- `cfg_req_ready_o`  out  1  config request ready
- `cfg_req_we_i`  in  1  1 = write, 0 = read
- `cfg_req_addr_i`  in  ADDR_WIDTH  config address
- `cfg_req_wdata_i`  in  DATA_WIDTH  config write data
- `cfg_rsp_valid_o`  out  1  config response valid
- `cfg_rsp_ready_i`  in  1  config response ready
- `cfg_rsp_rdata_o`  out  DATA_WIDTH  read data; 0 for a write ack
- `lkp_req_valid_i`  in  1  lookup request valid
- `lkp_req_ready_o`  out  1  lookup request ready
- `lkp_req_addr_i`  in  ADDR_WIDTH  lookup address
- `lkp_rsp_valid_o`  out  1  lookup response valid
- `lkp_rsp_ready_i`  in  1  lookup response ready
- `lkp_rsp_data_o`  out  DATA_WIDTH  lookup data

## Operation
- States: CLEAR, DRAIN, RUN.
- Reset:
  - state = CLEAR, sweep counter = 0.
  - `init_done_o`, both readies, both response valids = 0.
  - Lookup buffer empty, in-flight flag = 0, last-write-valid = 0.
- CLEAR:
  - Port 0 writes CLEAR_VALUE at the counter address, one address per cycle; the counter increments.
  - After writing address DEPTH-1, go to RUN.
  - Both readies stay 0.
  - Pending lookup responses remain deliverable.
- RUN: `init_done_o` = 1.
  - `clear_req_i` high → go to DRAIN. The request is latched and never lost.
- DRAIN:
  - Both readies = 0.
  - Wait until the cfg response has been accepted and the lookup in-flight flag = 0.
  - Then go to CLEAR with counter = 0.
- Config path, port 0:
  - `cfg_req_ready_o` = RUN & !`cfg_rsp_valid_o`, so at most one config op is outstanding.
  - Write on handshake: RAM write in the same cycle; ack response next cycle with rdata = 0.
  - Read on handshake: port-0 read; response next cycle.
  - `cfg_rsp_rdata_o` is driven directly from RAM port-0 output. It stays stable until accepted because no port-0 operation occurs while a response is pending.
- Lookup path, port 1:
  - `lkp_req_ready_o` = RUN & !hazard & (count + inflight < 2), with count = buffer occupancy (0..2).
  - hazard = last_write_valid & (last_write_addr == `lkp_req_addr_i`).
    - last_write_valid/last_write_addr register any port-0 write of the previous cycle, sweep writes included.
    - The combinational dependence of ready on the address is intended.
  - A lookup and a config write to the same address in the same cycle: the lookup returns the OLD data (the lookup is ordered first).
  - Response is fall-through:
    - `lkp_rsp_valid_o` = (count > 0) | inflight.
    - `lkp_rsp_data_o` = buffer head if count > 0, else RAM port-1 output.
    - Port-1 data is enqueued when inflight is set and it is not consumed directly.
  - Responses return strictly in request order.

## Timing
- Sweep:
  - Write cycles = DEPTH.
  - `init_done_o` rises the cycle after the address DEPTH-1 write.
  - Sweep starts in the first cycle after `rst_n` is released.
- Config latency: handshake at cycle t → `cfg_rsp_valid_o` at t+1. Maximum throughput is 1 op per 2 cycles.
- Lookup latency:
  - Handshake at t → `lkp_rsp_valid_o` at t+1.
  - Sustained 1 per cycle while `lkp_rsp_ready_i` = 1.
  - A hazard stalls exactly 1 cycle.
- Backpressure:
  - At most 2 lookups are buffered or in flight.
  - Valid and data hold stable until the handshake.
- Reset asserted mid-operation, including mid-sweep:
  - In-flight and buffered responses are discarded.
  - The sweep restarts from address 0.

## Test plan
- Reset release with ADDR_WIDTH=4 → readies 0 for 16 cycles, `init_done_o` high on cycle 17, then a read of every address returns 0.
- Cfg write addr 5 = 0x123 at t → ack at t+1 with rdata 0. Cfg read addr 5 → rdata 0x123, held unchanged while `cfg_rsp_ready_i` = 0 for 5 cycles.
- Cfg write addr 7 = 0xA at t, lookup addr 7 at t+1 → `lkp_req_ready_o` = 0 at t+1; accepted at t+2; response 0xA at t+3. Lookup addr 8 at t+1 is accepted with no stall.
- Same-cycle cfg write addr 3 = 0xB and lookup addr 3, old value 0 → lookup response 0, and a later lookup returns 0xB.
- Back-to-back lookups to addr 1,2,3,4 with `lkp_rsp_ready_i` = 0 → only 2 accepted. Release ready → responses arrive in order, then 3 and 4 follow, no loss or duplication.
- `clear_req_i` during a pending cfg response → DRAIN until the response is accepted, then a DEPTH-cycle sweep. A read of addr 5 afterwards returns 0. Reset asserted mid-sweep restarts the sweep from addr 0.

Source files
------------

// File: rtl/rab_ram_tp_ctrl.sv
// RAB two-port BRAM controller: clears the RAM after reset or on request and
// shares it between a serialised config port (port 0) and a streaming lookup port (port 1).
module rab_ram_tp_ctrl #(
  parameter int unsigned           ADDR_WIDTH  = 10,
  parameter int unsigned           DATA_WIDTH  = 36,
  parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear_req_i,
  output logic                  init_done_o,
  input  logic                  cfg_req_valid_i,
  output logic                  cfg_req_ready_o,
  input  logic                  cfg_req_we_i,
  input  logic [ADDR_WIDTH-1:0] cfg_req_addr_i,
  input  logic [DATA_WIDTH-1:0] cfg_req_wdata_i,
  output logic                  cfg_rsp_valid_o,
  input  logic                  cfg_rsp_ready_i,
  output logic [DATA_WIDTH-1:0] cfg_rsp_rdata_o,
  input  logic                  lkp_req_valid_i,
  output logic                  lkp_req_ready_o,
  input  logic [ADDR_WIDTH-1:0] lkp_req_addr_i,
  output logic                  lkp_rsp_valid_o,
  input  logic                  lkp_rsp_ready_i,
  output logic [DATA_WIDTH-1:0] lkp_rsp_data_o
);

  localparam int unsigned DEPTH = 2**ADDR_WIDTH;

  typedef enum logic [1:0] {
    ST_CLEAR,
    ST_DRAIN,
    ST_RUN
  } state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] sweep_cnt_q, sweep_cnt_d;

  logic                  cfg_rsp_valid_q, cfg_rsp_valid_d;
  logic                  cfg_rsp_we_q, cfg_rsp_we_d;

  logic                  inflight_q, inflight_d;
  logic [1:0]            lkp_count_q, lkp_count_d;
  logic [DATA_WIDTH-1:0] lkp_buf_q [2];
  logic [DATA_WIDTH-1:0] lkp_buf_d [2];

  logic                  last_wr_valid_q, last_wr_valid_d;
  logic [ADDR_WIDTH-1:0] last_wr_addr_q, last_wr_addr_d;

  logic                  run;
  logic                  hazard;
  logic                  cfg_fire;
  logic                  lkp_fire;
  logic                  lkp_pop_buf;
  logic                  lkp_enq;

  logic                  ram_en0;
  logic                  ram_we0;
  logic [ADDR_WIDTH-1:0] ram_addr0;
  logic [DATA_WIDTH-1:0] ram_wdata0;
  logic [DATA_WIDTH-1:0] ram_rdata0;
  logic                  ram_en1;
  logic [ADDR_WIDTH-1:0] ram_addr1;
  logic [DATA_WIDTH-1:0] ram_rdata1;
  logic [DATA_WIDTH-1:0] ram_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_CLEAR;
      sweep_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      sweep_cnt_q <= sweep_cnt_d;
    end
  end

  // DRAIN only hands over to the sweep once no port-0 or port-1 result is still owed.
  always_comb begin
    state_d     = state_q;
    sweep_cnt_d = sweep_cnt_q;
    unique case (state_q)
      ST_CLEAR: begin
        sweep_cnt_d = sweep_cnt_q + ADDR_WIDTH'(1);
        if (sweep_cnt_q == '1) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (clear_req_i) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (!cfg_rsp_valid_q && !inflight_q) begin
          state_d     = ST_CLEAR;
          sweep_cnt_d = '0;
        end
      end
      default: begin
        state_d     = ST_CLEAR;
        sweep_cnt_d = '0;
      end
    endcase
  end

  always_comb begin
    run             = (state_q == ST_RUN);
    init_done_o     = run;
    hazard          = last_wr_valid_q && (last_wr_addr_q == lkp_req_addr_i);
    cfg_req_ready_o = run && !cfg_rsp_valid_q;
    lkp_req_ready_o = run && !hazard && ((lkp_count_q + {1'b0, inflight_q}) < 2'd2);
    cfg_fire        = cfg_req_valid_i && cfg_req_ready_o;
    lkp_fire        = lkp_req_valid_i && lkp_req_ready_o;

    cfg_rsp_valid_o = cfg_rsp_valid_q;
    cfg_rsp_rdata_o = cfg_rsp_we_q ? '0 : ram_rdata0;
    lkp_rsp_valid_o = (lkp_count_q != 2'd0) || inflight_q;
    lkp_rsp_data_o  = (lkp_count_q != 2'd0) ? lkp_buf_q[0] : ram_rdata1;

    // Port 0 belongs to the sweep in CLEAR and to the config requester otherwise.
    if (state_q == ST_CLEAR) begin
      ram_en0    = rst_n;
      ram_we0    = rst_n;
      ram_addr0  = sweep_cnt_q;
      ram_wdata0 = CLEAR_VALUE;
    end else begin
      ram_en0    = cfg_fire;
      ram_we0    = cfg_fire && cfg_req_we_i;
      ram_addr0  = cfg_req_addr_i;
      ram_wdata0 = cfg_req_wdata_i;
    end
    ram_en1   = lkp_fire;
    ram_addr1 = lkp_req_addr_i;
  end

  always_comb begin
    cfg_rsp_valid_d = cfg_fire || (cfg_rsp_valid_q && !cfg_rsp_ready_i);
    cfg_rsp_we_d    = cfg_fire ? cfg_req_we_i : cfg_rsp_we_q;
    last_wr_valid_d = ram_we0;
    last_wr_addr_d  = ram_addr0;
    inflight_d      = lkp_fire;

    // Port-1 data bypasses the buffer only when nothing older is queued and the consumer takes it.
    lkp_buf_d   = lkp_buf_q;
    lkp_count_d = lkp_count_q;
    lkp_pop_buf = (lkp_count_q != 2'd0) && lkp_rsp_ready_i;
    lkp_enq     = inflight_q && !((lkp_count_q == 2'd0) && lkp_rsp_ready_i);
    if (lkp_pop_buf) begin
      lkp_buf_d[0] = lkp_buf_q[1];
      lkp_count_d  = lkp_count_q - 2'd1;
    end
    if (lkp_enq) begin
      if (lkp_count_d == 2'd0) begin
        lkp_buf_d[0] = ram_rdata1;
      end else begin
        lkp_buf_d[1] = ram_rdata1;
      end
      lkp_count_d = lkp_count_d + 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cfg_rsp_valid_q <= 1'b0;
      cfg_rsp_we_q    <= 1'b0;
      inflight_q      <= 1'b0;
      lkp_count_q     <= 2'd0;
      last_wr_valid_q <= 1'b0;
      last_wr_addr_q  <= '0;
    end else begin
      cfg_rsp_valid_q <= cfg_rsp_valid_d;
      cfg_rsp_we_q    <= cfg_rsp_we_d;
      inflight_q      <= inflight_d;
      lkp_count_q     <= lkp_count_d;
      last_wr_valid_q <= last_wr_valid_d;
      last_wr_addr_q  <= last_wr_addr_d;
    end
  end

  always_ff @(posedge clk) begin
    lkp_buf_q <= lkp_buf_d;
  end

  // No-change BRAM: port-0 output holds across writes; a same-cycle port-1 read sees the old word.
  always_ff @(posedge clk) begin
    if (ram_en0) begin
      if (ram_we0) begin
        ram_mem[ram_addr0] <= ram_wdata0;
      end else begin
        ram_rdata0 <= ram_mem[ram_addr0];
      end
    end
    if (ram_en1) begin
      ram_rdata1 <= ram_mem[ram_addr1];
    end
  end

endmodule
